// File: rtl/gemm_drain_quant.sv
// gemm_drain_quant: snapshots the MxN accumulator grid of the systolic array,
// then streams it out one requantized row per beat.
//
// Output handshake: out_valid/out_ready. A row transfers on a rising edge where
// out_valid && out_ready. Once out_valid is high, out_row and out_row_idx stay
// stable until that transfer. out_valid does not depend combinationally on
// out_ready.
module gemm_drain_quant #(
    parameter int M       = 16,
    parameter int N       = 16,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 8,
    parameter int SCALE_W = 16,
    parameter int SHIFT_W = 6,
    localparam int IDX_W  = (M > 1) ? $clog2(M) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            acc_valid_in,
    input  logic [M-1:0][N-1:0][ACC_W-1:0]  acc_in,
    input  logic [SCALE_W-1:0]              scale,
    input  logic [SHIFT_W-1:0]              shift,
    input  logic                            relu_en,
    output logic                            busy,
    output logic                            captured,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N-1:0][OUT_W-1:0]         out_row,
    output logic [IDX_W-1:0]                out_row_idx,
    output logic                            done,
    output logic [1:0]                      dbg_state
);

    // Exact product width, and the largest shift that still keeps one
    // magnitude bit of the product.
    localparam int P_W    = ACC_W + SCALE_W + 1;
    localparam int SH_MAX = ACC_W + SCALE_W - 1;
    localparam int SH_W   = $clog2(SH_MAX + 1);
    // Row pointer counts 0..M so "all rows loaded" is a distinct value.
    localparam int PTR_W  = $clog2(M + 1);

    // Saturation bounds at the widened rounding width.
    localparam logic signed [P_W:0] SAT_HI = (P_W+1)'((1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [P_W:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t                         state_q, state_d;

    // Snapshot of the grid and requant settings; no reset needed, only read
    // after a capture has written them.
    logic [M-1:0][N-1:0][ACC_W-1:0] buf_q;
    logic [SCALE_W-1:0]             scale_q;
    logic [SH_W-1:0]                shift_q;
    logic                           relu_q;

    logic [PTR_W-1:0]               row_ptr_q, row_ptr_d;
    logic                           out_valid_q, out_valid_d;
    logic [N-1:0][OUT_W-1:0]        out_row_q, out_row_d;
    logic [IDX_W-1:0]               out_row_idx_q, out_row_idx_d;
    logic                           captured_q, captured_d;

    logic                           capture;
    logic                           fire;
    logic                           last_fire;
    logic                           load;
    logic [SH_W-1:0]                shift_clamped;
    logic [N-1:0][ACC_W-1:0]        rd_row;
    logic [N-1:0][OUT_W-1:0]        quant_row;

    // Requantize one element: exact multiply, round half up, arithmetic
    // shift, saturate, optional relu after saturation. The rounding add is
    // done one bit wider than the product so it cannot overflow.
    function automatic logic [OUT_W-1:0] requant(
        input logic [ACC_W-1:0]   acc,
        input logic [SCALE_W-1:0] scl,
        input logic [SH_W-1:0]    sh,
        input logic               relu
    );
        logic signed [P_W-1:0] prod;
        logic signed [P_W:0]   rnd;
        logic signed [P_W:0]   sum;
        logic signed [P_W:0]   r;
        logic [OUT_W-1:0]      sat;
        prod = P_W'($signed(acc)) * P_W'($signed({1'b0, scl}));
        rnd  = '0;
        if (sh != '0) begin
            rnd = (P_W+1)'(1) << (sh - 1'b1);
        end
        sum = $signed({prod[P_W-1], prod}) + rnd;
        r   = sum >>> sh;
        if (r > SAT_HI) begin
            sat = SAT_HI[OUT_W-1:0];
        end else if (r < SAT_LO) begin
            sat = SAT_LO[OUT_W-1:0];
        end else begin
            sat = r[OUT_W-1:0];
        end
        if (relu && sat[OUT_W-1]) begin
            sat = '0;
        end
        return sat;
    endfunction

    // Clamp the requested shift so oversized shifts behave like the maximum.
    always_comb begin
        if (32'(shift) > 32'(SH_MAX)) begin
            shift_clamped = SH_W'(SH_MAX);
        end else begin
            shift_clamped = SH_W'(shift);
        end
    end

    assign capture   = (state_q == ST_IDLE) && start && acc_valid_in;
    assign fire      = out_valid_q && out_ready;
    assign last_fire = fire && (out_row_idx_q == IDX_W'(M - 1));
    assign load      = (state_q == ST_EMIT) && (row_ptr_q != PTR_W'(M))
                       && (!out_valid_q || fire);

    // Select the row about to be loaded and requantize all N elements.
    assign rd_row = buf_q[IDX_W'(row_ptr_q)];

    // Parallel requant of the selected row.
    always_comb begin
        quant_row = '0;
        for (int j = 0; j < N; j++) begin
            quant_row[j] = requant(rd_row[j], scale_q, shift_q, relu_q);
        end
    end

    // FSM next state and state-decoded outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                busy = 1'b1;
                if (last_fire) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register and row pointer: load a new row whenever the register
    // is empty or its row is being taken this cycle.
    always_comb begin
        row_ptr_d     = row_ptr_q;
        out_valid_d   = out_valid_q;
        out_row_d     = out_row_q;
        out_row_idx_d = out_row_idx_q;
        captured_d    = capture;
        if (capture) begin
            row_ptr_d = '0;
        end
        if (last_fire) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_row_d     = quant_row;
            out_row_idx_d = IDX_W'(row_ptr_q);
            out_valid_d   = 1'b1;
            row_ptr_d     = row_ptr_q + 1'b1;
        end
    end

    // Snapshot grid and requant settings on an accepted start.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_q   <= acc_in;
            scale_q <= scale;
            shift_q <= shift_clamped;
            relu_q  <= relu_en;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            row_ptr_q     <= '0;
            out_valid_q   <= 1'b0;
            out_row_q     <= '0;
            out_row_idx_q <= '0;
            captured_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_ptr_q     <= row_ptr_d;
            out_valid_q   <= out_valid_d;
            out_row_q     <= out_row_d;
            out_row_idx_q <= out_row_idx_d;
            captured_q    <= captured_d;
        end
    end

    assign captured    = captured_q;
    assign out_valid   = out_valid_q;
    assign out_row     = out_row_q;
    assign out_row_idx = out_row_idx_q;
    assign dbg_state   = state_q;

endmodule
